// File: rtl/iter_div_if.sv
// iter_div_if: request/response bundle for the iterative divider.
//   Request : in_valid, in_ready, op_signed, op_word, dividend, divisor
//   Response: out_valid, out_ready, quotient, remainder
//   master  = the requester/consumer (ALU issue side)
//   slave   = the divider itself
interface iter_div_if #(
    parameter int unsigned XLEN = 64
);
    logic            in_valid;
    logic            in_ready;
    logic            op_signed;
    logic            op_word;
    logic [XLEN-1:0] dividend;
    logic [XLEN-1:0] divisor;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] quotient;
    logic [XLEN-1:0] remainder;

    modport master (
        output in_valid, op_signed, op_word, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder
    );

    modport slave (
        input  in_valid, op_signed, op_word, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder
    );
endinterface

// File: rtl/iter_div.sv
// iter_div: iterative radix-2 restoring divider, quotient and remainder together.
// Full-width (XLEN) and word (XLEN/2, sign-extended result) operations, signed
// or unsigned. Divide-by-zero and signed overflow finish one cycle after accept.
// Ports:
//   clk   - clock, rising edge
//   rst   - synchronous active-high reset
//   flush - synchronous kill of the in-flight operation
//   bus   - iter_div_if slave: ready/valid request and response channels
module iter_div #(
    parameter int unsigned XLEN = 64
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      flush,
    iter_div_if.slave bus
);
    localparam int unsigned W  = XLEN / 2;
    localparam int unsigned CW = $clog2(XLEN + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

    state_e          state_q, state_d;
    logic [XLEN:0]   rem_q, rem_d;       // partial remainder, N+1 bits
    logic [XLEN-1:0] dq_q, dq_d;         // dividend bits shift out the top, quotient bits in the bottom
    logic [XLEN-1:0] dvs_q, dvs_d;       // divisor magnitude
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            negq_q, negq_d;
    logic            negr_q, negr_d;
    logic            word_q, word_d;
    logic [XLEN-1:0] quotient_q, quotient_d;
    logic [XLEN-1:0] remainder_q, remainder_d;

    function automatic logic [XLEN-1:0] wext(input logic [XLEN-1:0] v, input logic w);
        return w ? {{W{v[W-1]}}, v[W-1:0]} : v;
    endfunction

    // Operand preparation for the accept cycle
    logic [XLEN-1:0] dvd_ext, dvs_ext, dvd_mag, dvs_mag, min_neg;
    logic            dvd_neg, dvs_neg, div_zero, ovf, accept;

    always_comb begin
        if (bus.op_word) begin
            dvd_ext = {{W{bus.op_signed & bus.dividend[W-1]}}, bus.dividend[W-1:0]};
            dvs_ext = {{W{bus.op_signed & bus.divisor[W-1]}}, bus.divisor[W-1:0]};
            min_neg = {{(W+1){1'b1}}, {(W-1){1'b0}}};
        end else begin
            dvd_ext = bus.dividend;
            dvs_ext = bus.divisor;
            min_neg = {1'b1, {(XLEN-1){1'b0}}};
        end
        dvd_neg  = bus.op_signed & dvd_ext[XLEN-1];
        dvs_neg  = bus.op_signed & dvs_ext[XLEN-1];
        dvd_mag  = dvd_neg ? -dvd_ext : dvd_ext;
        dvs_mag  = dvs_neg ? -dvs_ext : dvs_ext;
        div_zero = (dvs_ext == '0);
        ovf      = bus.op_signed & (dvd_ext == min_neg) & (dvs_ext == '1);
        accept   = bus.in_valid & (state_q == IDLE) & ~flush;
    end

    // One restoring step. rem_q never exceeds the divisor, so the top bit of
    // the shifted value is always 0 and a negative trial shows in the MSB.
    logic [XLEN+1:0] shifted, trial;
    logic            qbit;
    logic [XLEN-1:0] q_next, q_fin, r_fin;

    always_comb begin
        shifted = {rem_q, dq_q[XLEN-1]};
        trial   = shifted - {2'b00, dvs_q};
        qbit    = ~trial[XLEN+1];
        q_next  = {dq_q[XLEN-2:0], qbit};
        q_fin   = negq_q ? -q_next : q_next;
        r_fin   = qbit ? trial[XLEN-1:0] : shifted[XLEN-1:0];
        r_fin   = negr_q ? -r_fin : r_fin;
    end

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        dq_d        = dq_q;
        dvs_d       = dvs_q;
        cnt_d       = cnt_q;
        negq_d      = negq_q;
        negr_d      = negr_q;
        word_d      = word_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    word_d = bus.op_word;
                    negq_d = dvd_neg ^ dvs_neg;
                    negr_d = dvd_neg;
                    dvs_d  = dvs_mag;
                    rem_d  = '0;
                    // Word dividends are left-aligned so the same MSB feeds every step
                    dq_d   = bus.op_word ? (dvd_mag << W) : dvd_mag;
                    cnt_d  = bus.op_word ? CW'(W - 1) : CW'(XLEN - 1);
                    if (div_zero) begin
                        quotient_d  = '1;
                        remainder_d = wext(dvd_ext, bus.op_word);
                        state_d     = DONE;
                    end else if (ovf) begin
                        quotient_d  = dvd_ext;
                        remainder_d = '0;
                        state_d     = DONE;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                rem_d = qbit ? trial[XLEN:0] : shifted[XLEN:0];
                dq_d  = q_next;
                if (cnt_q == '0) begin
                    quotient_d  = wext(q_fin, word_q);
                    remainder_d = wext(r_fin, word_q);
                    state_d     = DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            dq_q        <= '0;
            dvs_q       <= '0;
            cnt_q       <= '0;
            negq_q      <= 1'b0;
            negr_q      <= 1'b0;
            word_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            dq_q        <= dq_d;
            dvs_q       <= dvs_d;
            cnt_q       <= cnt_d;
            negq_q      <= negq_d;
            negr_q      <= negr_d;
            word_q      <= word_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE) & ~flush;
    assign bus.out_valid = (state_q == DONE);
    assign bus.quotient  = quotient_q;
    assign bus.remainder = remainder_q;
endmodule

// File: tb/tb_iter_div.sv
// tb_iter_div: directed test of iter_div with XLEN = 64.
module tb_iter_div;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    iter_div_if #(.XLEN(64)) bus_if ();

    iter_div #(.XLEN(64)) dut (
        .clk  (clk),
        .rst  (rst),
        .flush(flush),
        .bus  (bus_if)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request, then count edges after the accept edge until out_valid.
    task automatic run_op(input string tag, input logic s, input logic w,
                          input logic [63:0] a, input logic [63:0] b,
                          input int lat_exp, input logic [63:0] eq, input logic [63:0] er);
        int lat;
        bus_if.op_signed = s;
        bus_if.op_word   = w;
        bus_if.dividend  = a;
        bus_if.divisor   = b;
        bus_if.in_valid  = 1'b1;
        check({tag, "_in_ready"}, 64'(bus_if.in_ready), 64'd1);
        tick();
        bus_if.in_valid  = 1'b0;
        bus_if.dividend  = 64'hDEAD_BEEF_DEAD_BEEF;
        bus_if.divisor   = 64'h0;
        bus_if.op_signed = ~s;
        bus_if.op_word   = ~w;
        lat = 0;
        while (!bus_if.out_valid && lat < 200) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'(lat_exp));
        check({tag, "_quot"}, bus_if.quotient, eq);
        check({tag, "_rem"}, bus_if.remainder, er);
    endtask

    initial begin
        int cnt;
        bus_if.in_valid  = 1'b0;
        bus_if.op_signed = 1'b0;
        bus_if.op_word   = 1'b0;
        bus_if.dividend  = '0;
        bus_if.divisor   = '0;
        bus_if.out_ready = 1'b1;

        // Reset state
        tick();
        tick();
        check("rst_valid", 64'(bus_if.out_valid), 64'd0);
        check("rst_quot", bus_if.quotient, 64'd0);
        check("rst_rem", bus_if.remainder, 64'd0);
        rst = 1'b0;
        #1;
        check("rst_in_ready", 64'(bus_if.in_ready), 64'd1);

        // -7 / 2 signed full width
        run_op("s64", 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64,
               64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF);
        tick();
        check("s64_post_valid", 64'(bus_if.out_valid), 64'd0);
        check("s64_post_ready", 64'(bus_if.in_ready), 64'd1);

        // Unsigned word, result sign-extended from bit 31
        run_op("uw", 1'b0, 1'b1, 64'h0000_0000_FFFF_FFFE, 64'd1, 32,
               64'hFFFF_FFFF_FFFF_FFFE, 64'd0);
        tick();

        // Signed word -100 / 7, upper operand bits are garbage
        run_op("sw", 1'b1, 1'b1, 64'h1234_5678_FFFF_FF9C, 64'hABCD_0000_0000_0007, 32,
               64'hFFFF_FFFF_FFFF_FFF2, 64'hFFFF_FFFF_FFFF_FFFE);
        tick();

        // 100 / -7 signed full width
        run_op("s64b", 1'b1, 1'b0, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 64,
               64'hFFFF_FFFF_FFFF_FFF2, 64'd2);
        tick();

        // Divide by zero
        run_op("div0", 1'b1, 1'b0, 64'h1234, 64'd0, 0,
               64'hFFFF_FFFF_FFFF_FFFF, 64'h1234);
        tick();

        // Signed word overflow
        run_op("ovf", 1'b1, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 0,
               64'hFFFF_FFFF_8000_0000, 64'd0);
        tick();

        // Backpressure
        bus_if.out_ready = 1'b0;
        run_op("bp", 1'b0, 1'b0, 64'd100, 64'd7, 64, 64'd14, 64'd2);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_valid", 64'(bus_if.out_valid), 64'd1);
            check("bp_quot", bus_if.quotient, 64'd14);
            check("bp_rem", bus_if.remainder, 64'd2);
            check("bp_in_ready", 64'(bus_if.in_ready), 64'd0);
        end
        bus_if.out_ready = 1'b1;
        #1;
        check("bp_hs_in_ready", 64'(bus_if.in_ready), 64'd0);
        tick();
        check("bp_after_valid", 64'(bus_if.out_valid), 64'd0);
        check("bp_after_ready", 64'(bus_if.in_ready), 64'd1);

        // Flush blocks an accept in IDLE (a div-by-zero would show next cycle)
        bus_if.op_signed = 1'b0;
        bus_if.op_word   = 1'b0;
        bus_if.dividend  = 64'd5;
        bus_if.divisor   = 64'd0;
        bus_if.in_valid  = 1'b1;
        flush = 1'b1;
        #1;
        check("flush_idle_ready", 64'(bus_if.in_ready), 64'd0);
        tick();
        flush = 1'b0;
        bus_if.in_valid = 1'b0;
        check("flush_idle_valid", 64'(bus_if.out_valid), 64'd0);

        // Flush mid-CALC
        bus_if.dividend = 64'd1000;
        bus_if.divisor  = 64'd3;
        bus_if.in_valid = 1'b1;
        tick();
        bus_if.in_valid = 1'b0;
        repeat (19) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        check("flush_valid", 64'(bus_if.out_valid), 64'd0);
        check("flush_ready", 64'(bus_if.in_ready), 64'd1);
        cnt = 0;
        for (int i = 0; i < 70; i++) begin
            tick();
            if (bus_if.out_valid) cnt++;
        end
        check("flush_no_result", 64'(cnt), 64'd0);
        run_op("post_flush", 1'b0, 1'b0, 64'd9, 64'd3, 64, 64'd3, 64'd0);
        tick();

        // Reset mid-CALC
        bus_if.dividend = 64'd50;
        bus_if.divisor  = 64'd5;
        bus_if.in_valid = 1'b1;
        tick();
        bus_if.in_valid = 1'b0;
        repeat (10) tick();
        rst = 1'b1;
        tick();
        check("rst_mid_valid", 64'(bus_if.out_valid), 64'd0);
        check("rst_mid_quot", bus_if.quotient, 64'd0);
        check("rst_mid_rem", bus_if.remainder, 64'd0);
        rst = 1'b0;
        #1;
        check("rst_mid_ready", 64'(bus_if.in_ready), 64'd1);
        cnt = 0;
        for (int i = 0; i < 70; i++) begin
            tick();
            if (bus_if.out_valid) cnt++;
        end
        check("rst_mid_no_result", 64'(cnt), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
